// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, grant encoding
// and the width of the minimum-wait counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        FETCH,
        DATA
    } grant_t;

    // Wide enough for any practical MIN_WAIT setting.
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant choice between the fetch and data requesters.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternate grants on ties;
// otherwise data always beats fetch).
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output logic   any_req,
    output grant_t grant
);

    assign any_req = i_req | d_req;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the history flop.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winner; the lone requester wins, ties are policy dependent.
    always_comb begin
        grant = FETCH;
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant = (last_grant == DATA) ? FETCH : DATA;
`else
            grant = DATA;
`endif
        end else if (d_req) begin
            grant = DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port RAM between instruction fetch
// (read-only) and the data port (load/store). One transaction at a time:
// IDLE -> ISSUE (strobe) -> WAIT (min wait + ram_busy) -> RESP (ack).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (handled in mem_arb_select).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MIN_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_busy,
    output logic              arb_busy
);

    localparam logic [WAIT_CNT_W-1:0] MIN_WAIT_CNT = WAIT_CNT_W'(MIN_WAIT);
    localparam logic [WAIT_CNT_W-1:0] ONE_CNT      = WAIT_CNT_W'(1);

    arb_state_t            state_reg,      state_next;
    grant_t                grant_reg,      grant_next;
    grant_t                last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0]     addr_reg,       addr_next;
    logic [DATA_W-1:0]     wdata_reg,      wdata_next;
    logic                  wen_reg,        wen_next;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg,   wait_cnt_next;
    logic [DATA_W-1:0]     i_rdata_reg,    i_rdata_next;
    logic [DATA_W-1:0]     d_rdata_reg,    d_rdata_next;

    logic   sel_any;
    grant_t sel_grant;

    mem_arb_select u_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_reg),
        .any_req    (sel_any),
        .grant      (sel_grant)
    );

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= FETCH;
            last_grant_reg <= DATA;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wen_reg        <= 1'b0;
            wait_cnt_reg   <= '0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wen_reg        <= wen_next;
            wait_cnt_reg   <= wait_cnt_next;
            i_rdata_reg    <= i_rdata_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wen_next        = wen_reg;
        wait_cnt_next   = wait_cnt_reg;
        i_rdata_next    = i_rdata_reg;
        d_rdata_next    = d_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (sel_any) begin
                    grant_next = sel_grant;
                    if (sel_grant == DATA) begin
                        addr_next  = d_addr;
                        wdata_next = d_wdata;
                        wen_next   = d_wen;
                    end else begin
                        addr_next  = i_addr;
                        wdata_next = '0;
                        wen_next   = 1'b0;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_next = MIN_WAIT_CNT;
                state_next    = WAIT;
            end
            WAIT: begin
                // The counter is judged on its post-decrement value, so
                // MIN_WAIT counts WAIT cycles including the one that exits.
                if ((wait_cnt_reg <= ONE_CNT) && !ram_busy) begin
                    wait_cnt_next = '0;
                    if (!wen_reg) begin
                        if (grant_reg == DATA) begin
                            d_rdata_next = ram_data_out;
                        end else begin
                            i_rdata_next = ram_data_out;
                        end
                    end
                    state_next = RESP;
                end else if (wait_cnt_reg != '0) begin
                    wait_cnt_next = wait_cnt_reg - ONE_CNT;
                end
            end
            RESP: begin
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registers so reset clears them at once.
    assign ram_addr         = (state_reg != IDLE) ? addr_reg  : '0;
    assign ram_data_in      = (state_reg != IDLE) ? wdata_reg : '0;
    assign ram_write_enable = (state_reg == ISSUE) &&  wen_reg;
    assign ram_read_enable  = (state_reg == ISSUE) && !wen_reg;
    assign i_ack            = (state_reg == RESP) && (grant_reg == FETCH);
    assign d_ack            = (state_reg == RESP) && (grant_reg == DATA);
    assign i_rdata          = i_rdata_reg;
    assign d_rdata          = d_rdata_reg;
    assign arb_busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int MIN_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] ram_addr;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic        ram_read_enable;
    logic [31:0] ram_data_out;
    logic        ram_busy;
    logic        arb_busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: last granted port (1 = data) and rdata values.
    bit          last_win = 1'b1;
    logic [31:0] exp_i_rdata = '0;
    logic [31:0] exp_d_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MIN_WAIT(MIN_WAIT)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req            (i_req),
        .i_addr           (i_addr),
        .i_rdata          (i_rdata),
        .i_ack            (i_ack),
        .d_req            (d_req),
        .d_wen            (d_wen),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_rdata          (d_rdata),
        .d_ack            (d_ack),
        .ram_addr         (ram_addr),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_out     (ram_data_out),
        .ram_busy         (ram_busy),
        .arb_busy         (arb_busy)
    );

    // Returns 1 when the data port should win among the pending requests.
    function automatic bit pick(input bit pi, input bit pd);
        if (pi && pd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !last_win;
`else
            return 1'b1;
`endif
        end
        return pd;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({i_ack, d_ack, ram_write_enable, ram_read_enable, arb_busy,
             ram_addr, ram_data_in, i_rdata, d_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got addr=%h din=%h ir=%h dr=%h ctl=%b want all zero",
                     ram_addr, ram_data_in, i_rdata, d_rdata,
                     {i_ack, d_ack, ram_write_enable, ram_read_enable, arb_busy});
        end
        $display("test_reset: outputs checked under reset");
    endtask

    // Runs one scenario starting in an IDLE cycle; b = ram_busy WAIT cycles
    // per transaction, again = data port re-requests a new address once.
    task automatic run_txn(input string tag, input bit iq, input bit dq, input bit wen,
                           input int b, input logic [31:0] iaddr, input logic [31:0] daddr,
                           input logic [31:0] wdat, input logic [31:0] rdat, input bit again);
        bit pend_i, pend_d, cur_d, cur_w, in_txn, again_left;
        int n_txn, done, cyc, exp_strobe, exp_ack, k0, last_ack, nwait;
        logic [31:0] cur_addr, cur_rdat;

        pend_i     = iq;
        pend_d     = dq;
        again_left = dq && again;
        n_txn      = int'(iq) + int'(dq) + int'(again_left);
        i_req      = iq;
        d_req      = dq;
        d_wen      = wen;
        i_addr     = iaddr;
        d_addr     = daddr;
        d_wdata    = wdat;
        ram_busy   = 1'b0;
        cur_d      = pick(pend_i, pend_d);
        cur_w      = 1'b0;
        cur_rdat   = rdat;
        exp_strobe = 1;
        exp_ack    = -1;
        k0         = 0;
        in_txn     = 1'b0;
        done       = 0;
        cyc        = 0;
        last_ack   = -10;
        nwait      = (MIN_WAIT > b + 1) ? MIN_WAIT : b + 1;

        while (!(done == n_txn && cyc > last_ack)) begin
            step();
            cyc++;
            if (cyc > 80) begin
                total++;
                bad++;
                $display("FAIL %s timeout got done=%0d want=%0d", tag, done, n_txn);
                i_req = 1'b0;
                d_req = 1'b0;
                break;
            end
            if (cyc == last_ack + 1) begin
                total++;
                if (arb_busy !== 1'b0 || ram_addr !== 32'h0) begin
                    bad++;
                    $display("FAIL %s bubble got busy=%b addr=%h want busy=0 addr=0",
                             tag, arb_busy, ram_addr);
                end
            end
            if (ram_read_enable || ram_write_enable) begin
                cur_w    = cur_d && wen;
                cur_addr = cur_d ? d_addr : i_addr;
                total++;
                if (cyc != exp_strobe) begin
                    bad++;
                    $display("FAIL %s strobe_cycle got=%0d want=%0d", tag, cyc, exp_strobe);
                end
                total++;
                if ({ram_write_enable, ram_read_enable} !== {cur_w, !cur_w}) begin
                    bad++;
                    $display("FAIL %s strobe_kind got we,re=%b%b want=%b%b", tag,
                             ram_write_enable, ram_read_enable, cur_w, !cur_w);
                end
                total++;
                if (ram_addr !== cur_addr) begin
                    bad++;
                    $display("FAIL %s ram_addr got=%h want=%h", tag, ram_addr, cur_addr);
                end
                if (cur_w) begin
                    total++;
                    if (ram_data_in !== d_wdata) begin
                        bad++;
                        $display("FAIL %s ram_data_in got=%h want=%h", tag, ram_data_in, d_wdata);
                    end
                end
                ram_data_out = cur_rdat;
                exp_ack      = cyc + 1 + nwait;
                k0           = cyc;
                in_txn       = 1'b1;
            end
            if (in_txn) begin
                ram_busy = (cyc - k0 >= 1) && (cyc - k0 <= b);
            end
            if (i_ack || d_ack) begin
                total++;
                if (cyc != exp_ack) begin
                    bad++;
                    $display("FAIL %s ack_cycle got=%0d want=%0d", tag, cyc, exp_ack);
                end
                total++;
                if ({d_ack, i_ack} !== {cur_d, !cur_d}) begin
                    bad++;
                    $display("FAIL %s ack_port got d,i=%b%b want=%b%b", tag,
                             d_ack, i_ack, cur_d, !cur_d);
                end
                if (!cur_w) begin
                    if (cur_d) exp_d_rdata = cur_rdat;
                    else       exp_i_rdata = cur_rdat;
                end
                total++;
                if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
                    bad++;
                    $display("FAIL %s rdata got i=%h d=%h want i=%h d=%h", tag,
                             i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
                end
                $display("%s: %s %s ack at cycle %0d", tag, cur_d ? "data" : "fetch",
                         cur_w ? "store" : "read", cyc);
                last_win = cur_d;
                done++;
                last_ack = cyc;
                in_txn   = 1'b0;
                ram_busy = 1'b0;
                if (cur_d) begin
                    if (again_left) begin
                        again_left = 1'b0;
                        d_addr     = d_addr ^ 32'h0000_0100;
                    end else begin
                        pend_d = 1'b0;
                        d_req  = 1'b0;
                    end
                end else begin
                    pend_i = 1'b0;
                    i_req  = 1'b0;
                end
                cur_rdat = ~cur_rdat;
                if (pend_i || pend_d) begin
                    cur_d      = pick(pend_i, pend_d);
                    exp_strobe = cyc + 2;
                end
            end
        end
    endtask

    task automatic test_fetch_only();
        run_txn("fetch_only", 1'b1, 1'b0, 1'b0, 0, 32'h0000_0010, 32'h0,
                32'h0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_store_busy();
        run_txn("store_busy", 1'b0, 1'b1, 1'b1, 4, 32'h0, 32'h0000_0040,
                32'h1234_5678, 32'hA5A5_A5A5, 1'b0);
    endtask

    task automatic test_simultaneous();
        run_txn("simul_1", 1'b1, 1'b1, 1'b0, 0, 32'h0000_0100, 32'h0000_0200,
                32'h0, 32'h1111_2222, 1'b0);
        run_txn("simul_2", 1'b1, 1'b1, 1'b0, 1, 32'h0000_0300, 32'h0000_0400,
                32'h0, 32'h3333_4444, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("back_to_back", 1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0000_0080,
                32'h0, 32'h5555_6666, 1'b1);
    endtask

    task automatic test_reset_wait();
        bit seen;
        seen     = 1'b0;
        d_req    = 1'b1;
        d_wen    = 1'b0;
        d_addr   = 32'h0000_0444;
        ram_busy = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = ram_read_enable;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_wait strobe got=0 want=1");
        end
        step();
        step();
        rst = 1'b1;
        #1;
        total++;
        if ({i_ack, d_ack, ram_write_enable, ram_read_enable, arb_busy,
             ram_addr, ram_data_in, i_rdata, d_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_wait outputs got addr=%h ir=%h dr=%h ctl=%b want all zero",
                     ram_addr, i_rdata, d_rdata,
                     {i_ack, d_ack, ram_write_enable, ram_read_enable, arb_busy});
        end
        d_req       = 1'b0;
        ram_busy    = 1'b0;
        last_win    = 1'b1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (i_ack || d_ack || arb_busy) begin
                bad++;
                $display("FAIL reset_wait idle got i_ack=%b d_ack=%b busy=%b want 0",
                         i_ack, d_ack, arb_busy);
            end
        end
        $display("reset_wait: abort checked");
    endtask

    task automatic test_random();
        bit iq, dq;
        logic [31:0] ia;
        for (int n = 0; n < 25; n++) begin
            iq = 1'($urandom_range(0, 1));
            dq = 1'($urandom_range(0, 1));
            if (!iq && !dq) dq = 1'b1;
            ia = $urandom;
            run_txn("random", iq, dq, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    ia, ia ^ 32'h8000_0000, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst          = 1'b1;
        i_req        = 1'b0;
        i_addr       = '0;
        d_req        = 1'b0;
        d_wen        = 1'b0;
        d_addr       = '0;
        d_wdata      = '0;
        ram_data_out = '0;
        ram_busy     = 1'b0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_fetch_only();
        test_store_busy();
        test_simultaneous();
        test_back_to_back();
        test_reset_wait();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
